// File: rtl/wp_pkg.sv
// Shared types and sizing for the waypoint sequencer.
// Holds the FSM state encoding, table geometry and the coordinate pair payload.
package wp_pkg;

  localparam int unsigned N_ENTRIES = 9;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned IDX_W     = 4;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    FETCH       = 3'd1,
    PRESENT     = 3'd2,
    WAIT_ARRIVE = 3'd3,
    DONE        = 3'd4,
    ERROR       = 3'd5
  } wp_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
  } wp_pair_t;

  // True when idx addresses the final table entry.
  function automatic logic is_last_idx(input logic [IDX_W-1:0] idx);
    return idx == IDX_W'(N_ENTRIES - 1);
  endfunction

endpackage

// File: rtl/wp_timeout_timer.sv
// Arrival watchdog: counts enabled cycles since the last clear and flags when
// the count reaches TIMEOUT_CYC. Saturates so it can never wrap back to zero.
module wp_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_expired_c = (r_cnt == CNT_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired_c) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/waypoint_sequencer.sv
// Walks an external coordinate table entry by entry, offering each (x, y) over
// valid/ready and waiting for the consumer's arrival pulse before advancing.
module waypoint_sequencer
  import wp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              loop_en,
  output logic [IDX_W-1:0]  tbl_idx,
  input  logic [DATA_W-1:0] tbl_x,
  input  logic [DATA_W-1:0] tbl_y,
  output logic              wp_valid,
  input  logic              wp_ready,
  output logic [DATA_W-1:0] wp_x,
  output logic [DATA_W-1:0] wp_y,
  output logic [IDX_W-1:0]  wp_idx,
  input  logic              arrived,
  output logic              busy,
  output logic              done,
  output logic              err
);

  wp_state_e        r_state;
  wp_state_e        w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  wp_pair_t         r_wp;
  wp_pair_t         w_tbl_pair;
  logic [IDX_W-1:0] r_wp_idx;
  logic             r_wp_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             w_valid_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_err_nxt;
  logic             w_load;
  logic             w_tmr_clr;
  logic             w_tmr_en;
  logic             w_expired;
  logic             w_last;

  assign w_tbl_pair = '{x: tbl_x, y: tbl_y};
  assign w_last     = is_last_idx(r_idx);

  wp_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_tmr_clr),
    .i_en       (w_tmr_en),
    .o_expired_c(w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; status outputs are derived from the next state so they
  // register in lockstep with it.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_err_nxt   = r_err;
    w_load      = 1'b0;
    w_tmr_clr   = 1'b0;
    w_tmr_en    = 1'b0;
    w_valid_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    if (abort) begin
      w_state_nxt = IDLE;
      w_err_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            w_idx_nxt   = '0;
            w_err_nxt   = 1'b0;
            w_state_nxt = FETCH;
          end
        end
        FETCH: begin
          w_load      = 1'b1;
          w_state_nxt = PRESENT;
        end
        PRESENT: begin
          if (r_wp_valid && wp_ready) begin
            w_tmr_clr   = 1'b1;
            w_state_nxt = WAIT_ARRIVE;
          end
        end
        WAIT_ARRIVE: begin
          w_tmr_en = 1'b1;
          // Arrival takes precedence over a timeout in the same cycle.
          if (arrived) begin
            if (!w_last) begin
              w_idx_nxt   = r_idx + IDX_W'(1);
              w_state_nxt = FETCH;
            end else if (loop_en) begin
              w_idx_nxt   = '0;
              w_state_nxt = FETCH;
            end else begin
              w_state_nxt = DONE;
            end
          end else if (w_expired) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ERROR;
          end
        end
        DONE: begin
          w_state_nxt = IDLE;
        end
        ERROR: begin
          if (start) begin
            w_err_nxt   = 1'b0;
            w_idx_nxt   = '0;
            w_state_nxt = FETCH;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end

    w_valid_nxt = (w_state_nxt == PRESENT);
    w_busy_nxt  = (w_state_nxt == FETCH) || (w_state_nxt == PRESENT) ||
                  (w_state_nxt == WAIT_ARRIVE);
    w_done_nxt  = (w_state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_wp       <= '0;
      r_wp_idx   <= '0;
      r_wp_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_idx      <= w_idx_nxt;
      r_wp_valid <= w_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      if (w_load) begin
        r_wp     <= w_tbl_pair;
        r_wp_idx <= r_idx;
      end
    end
  end

  assign tbl_idx  = r_idx;
  assign wp_valid = r_wp_valid;
  assign wp_x     = r_wp.x;
  assign wp_y     = r_wp.y;
  assign wp_idx   = r_wp_idx;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule
